id_stage_pipe: RTL

Parametrised, registered instruction-decode stage for the ARM-subset pipeline. It decodes one 32-bit instruction per cycle, evaluates its condition field against the NZCV status, and reads two operands from an internal register file. The register file takes its write port from writeback. Results go into an ID/EX pipeline register with freeze, flush and bubble insertion. The stage sits between the IF/ID register and the execute stage.

---
 rtl/id_stage_pipe_pkg.sv | 109 ++++++++++
 rtl/id_stage_pipe_cond_check.sv | 37 +++
 rtl/id_stage_pipe.sv | 123 ++++++++++++
 3 files changed

// File: rtl/id_stage_pipe_pkg.sv
// Shared decode definitions for the instruction-decode stage: ALU command
// codes, instruction field encodings and the control bundle carried into
// the ID/EX register.
package id_pkg;

  // ALU commands driven onto exe_cmd
  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  // Data-processing opcodes (instruction[24:21])
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  // Instruction classes (instruction[27:26])
  localparam logic [1:0] MODE_ALU = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  // Condition codes (instruction[31:28])
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // Control bundle loaded into ID/EX; all-zero is a bubble
  typedef struct packed {
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       b;
    logic       s;
    logic       imm;
    logic [3:0] exe_cmd;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  // Map the instruction class/opcode/S/I bits onto the control bundle
  function automatic ctrl_t decode_ctrl(input logic [1:0] mode, input logic imm,
                                        input logic [3:0] opcode, input logic s);
    ctrl_t c;
    c = CTRL_NONE;
    case (mode)
      MODE_ALU: begin
        c.s   = s;
        c.imm = imm;
        case (opcode)
          OP_MOV: begin c.exe_cmd = CMD_MOV; c.wb_en = 1'b1; end
          OP_MVN: begin c.exe_cmd = CMD_MVN; c.wb_en = 1'b1; end
          OP_ADD: begin c.exe_cmd = CMD_ADD; c.wb_en = 1'b1; end
          OP_ADC: begin c.exe_cmd = CMD_ADC; c.wb_en = 1'b1; end
          OP_SUB: begin c.exe_cmd = CMD_SUB; c.wb_en = 1'b1; end
          OP_SBC: begin c.exe_cmd = CMD_SBC; c.wb_en = 1'b1; end
          OP_AND: begin c.exe_cmd = CMD_AND; c.wb_en = 1'b1; end
          OP_ORR: begin c.exe_cmd = CMD_ORR; c.wb_en = 1'b1; end
          OP_EOR: begin c.exe_cmd = CMD_EOR; c.wb_en = 1'b1; end
          OP_CMP: c.exe_cmd = CMD_SUB;
          OP_TST: c.exe_cmd = CMD_AND;
          default: c.exe_cmd = CMD_NOP;
        endcase
      end
      MODE_MEM: begin
        // Only the add-offset form is a load/store; S selects LDR vs STR
        if (opcode == OP_ADD) begin
          c.exe_cmd = CMD_ADD;
          c.imm     = imm;
          if (s) begin
            c.mem_r_en = 1'b1;
            c.wb_en    = 1'b1;
          end else begin
            c.mem_w_en = 1'b1;
          end
        end
      end
      MODE_BR: c.b = 1'b1;
      default: c = CTRL_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_stage_pipe_cond_check.sv
// Condition evaluator: compares the instruction condition field against
// the {N,Z,C,V} status flags.
module cond_check
  import id_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] status,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = status;

  // Pure combinational condition table; 1111 never executes
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Instruction-decode stage: decodes one instruction per cycle, gates it on
// its condition field, reads two operands from the register file and loads
// everything into the ID/EX register (freeze / flush / bubble aware).
// Optional macro ID_WB_BYPASS_EN forwards a same-cycle writeback to the
// read ports; without it the ports return stored values only.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  localparam int RA_W    = (NUM_REGS > 16) ? $clog2(NUM_REGS) : 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              hazard,
  input  logic              in_valid,
  input  logic [31:0]       instruction,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [3:0]        status,
  input  logic              wb_en,
  input  logic [RA_W-1:0]   wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  output logic [RA_W-1:0]   src1,
  output logic [RA_W-1:0]   src2,
  output logic              two_src,
  output logic              out_valid,
  output logic [DATA_W-1:0] pc_out,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic              mem_w_en_out,
  output logic              b_out,
  output logic              s_out,
  output logic              imm_out,
  output logic [3:0]        exe_cmd,
  output logic [11:0]       shift_operand,
  output logic [23:0]       simm24,
  output logic [RA_W-1:0]   dest,
  output logic [DATA_W-1:0] val_rn,
  output logic [DATA_W-1:0] val_rm
);

  logic [1:0] mode;
  logic       imm_bit, s_bit, store, cond_pass, live;
  logic [3:0] opcode;
  ctrl_t      ctrl, ctrl_q;
  logic [DATA_W-1:0] rf [NUM_REGS];
  logic [DATA_W-1:0] rd1, rd2;

  assign mode    = instruction[27:26];
  assign imm_bit = instruction[25];
  assign opcode  = instruction[24:21];
  assign s_bit   = instruction[20];
  assign store   = (mode == MODE_MEM) && (opcode == OP_ADD) && !s_bit;

  // Stores read Rd as their data source on the second port
  assign src1    = RA_W'(instruction[19:16]);
  assign src2    = store ? RA_W'(instruction[15:12]) : RA_W'(instruction[3:0]);
  assign two_src = ~imm_bit | store;

  assign ctrl = decode_ctrl(mode, imm_bit, opcode, s_bit);

  cond_check u_cond (
    .cond   (instruction[31:28]),
    .status (status),
    .pass   (cond_pass)
  );

  // Register file: writeback port, cleared on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (wb_en && (int'(wb_dest) < NUM_REGS)) begin
      rf[wb_dest] <= wb_value;
    end
  end

  // Combinational read ports, with optional same-cycle writeback forwarding
  always_comb begin
    rd1 = (int'(src1) < NUM_REGS) ? rf[src1] : '0;
    rd2 = (int'(src2) < NUM_REGS) ? rf[src2] : '0;
`ifdef ID_WB_BYPASS_EN
    if (wb_en && (wb_dest == src1)) rd1 = wb_value;
    if (wb_en && (wb_dest == src2)) rd2 = wb_value;
`endif
  end

  // An instruction is loaded live only if nothing turns it into a bubble
  assign live = !flush && !hazard && in_valid && cond_pass;

  // ID/EX register: flush beats freeze; bubbles still load the data fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      ctrl_q        <= CTRL_NONE;
      pc_out        <= '0;
      shift_operand <= '0;
      simm24        <= '0;
      dest          <= '0;
      val_rn        <= '0;
      val_rm        <= '0;
    end else if (flush || !freeze) begin
      out_valid     <= live;
      ctrl_q        <= live ? ctrl : CTRL_NONE;
      pc_out        <= pc_in;
      shift_operand <= instruction[11:0];
      simm24        <= instruction[23:0];
      dest          <= RA_W'(instruction[15:12]);
      val_rn        <= rd1;
      val_rm        <= rd2;
    end
  end

  assign wb_en_out    = ctrl_q.wb_en;
  assign mem_r_en_out = ctrl_q.mem_r_en;
  assign mem_w_en_out = ctrl_q.mem_w_en;
  assign b_out        = ctrl_q.b;
  assign s_out        = ctrl_q.s;
  assign imm_out      = ctrl_q.imm;
  assign exe_cmd      = ctrl_q.exe_cmd;

endmodule
